// File: rtl/dot_matrix_pkg.sv
// rtl/dot_matrix_pkg.sv - glyph codes and FSM encoding shared with the display driver
package dot_matrix_pkg;

  localparam int unsigned TIMER_W = 16;

  typedef enum logic [1:0] {
    GLYPH_WRONG   = 2'd0,
    GLYPH_CORRECT = 2'd1,
    GLYPH_ERROR   = 2'd2,
    GLYPH_OK      = 2'd3
  } glyph_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef enum logic {
    SRC_IN  = 1'b0,
    SRC_ANS = 1'b1
  } src_e;

  function automatic glyph_e ans_glyph(input logic ok);
    return ok ? GLYPH_CORRECT : GLYPH_WRONG;
  endfunction

  function automatic glyph_e in_glyph(input logic ok);
    return ok ? GLYPH_OK : GLYPH_ERROR;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - 16-bit down counter timing the SHOW and GAP phases
module hold_timer
  import dot_matrix_pkg::*;
(
  input  logic               clk_div,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Loaded with N-1 so the phase lasts exactly N cycles; parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_div) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/dot_matrix_scheduler.sv
// rtl/dot_matrix_scheduler.sv - arbitrates input/answer glyphs onto a single dot-matrix display
module dot_matrix_scheduler
  import dot_matrix_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 2000,
  parameter int unsigned GAP_TICKS  = 250
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_req,
  input  logic       in_ok,
  input  logic       ans_req,
  input  logic       ans_ok,
  output logic [1:0] glyph,
  output logic       disp_en,
  output logic       ack_in,
  output logic       ack_ans,
  output logic       busy,
  output logic       overrun
);

  localparam logic [TIMER_W-1:0] HOLD_VAL = TIMER_W'(HOLD_TICKS - 1);
  localparam logic [TIMER_W-1:0] GAP_VAL  = TIMER_W'(GAP_TICKS - 1);

  state_e state_q, state_d;
  src_e   src_q, src_d;
  glyph_e glyph_q, glyph_d;
  logic   disp_en_q, disp_en_d;
  logic   ack_in_q, ack_in_d;
  logic   ack_ans_q, ack_ans_d;
  logic   overrun_q, overrun_d;
  logic   in_vld_q, in_vld_d, in_res_q, in_res_d;
  logic   ans_vld_q, ans_vld_d, ans_res_q, ans_res_d;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_done;

  logic start_ans, start_in, preempt, consume_ans, consume_in;

  hold_timer u_hold_timer (
    .clk_div  (clk_div),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Answers outrank inputs both when leaving IDLE and while an input glyph is lit.
  always_comb begin
    start_ans   = !clear && (state_q == ST_IDLE) && ans_vld_q;
    start_in    = !clear && (state_q == ST_IDLE) && !ans_vld_q && in_vld_q;
    preempt     = !clear && (state_q == ST_SHOW) && (src_q == SRC_IN) && ans_vld_q;
    consume_ans = start_ans || preempt;
    consume_in  = start_in;
  end

  always_comb begin
    in_vld_d  = in_vld_q;
    in_res_d  = in_res_q;
    ans_vld_d = ans_vld_q;
    ans_res_d = ans_res_q;
    overrun_d = overrun_q;
    if (clear) begin
      in_vld_d  = 1'b0;
      ans_vld_d = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (consume_in) in_vld_d = 1'b0;
      if (in_req) begin
        in_vld_d = 1'b1;
        in_res_d = in_ok;
        if (in_vld_q && !consume_in) overrun_d = 1'b1;
      end
      if (consume_ans) ans_vld_d = 1'b0;
      if (ans_req) begin
        ans_vld_d = 1'b1;
        ans_res_d = ans_ok;
        if (ans_vld_q && !consume_ans) overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_ans || start_in) state_d = ST_SHOW;
        ST_SHOW: if (!preempt && timer_done) state_d = ST_GAP;
        ST_GAP:  if (timer_done) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    glyph_d    = glyph_q;
    src_d      = src_q;
    ack_in_d   = 1'b0;
    ack_ans_d  = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;
    if (clear) begin
      timer_load = 1'b1;
    end else if (consume_ans) begin
      glyph_d    = ans_glyph(ans_res_q);
      src_d      = SRC_ANS;
      ack_ans_d  = 1'b1;
      timer_load = 1'b1;
      timer_val  = HOLD_VAL;
    end else if (consume_in) begin
      glyph_d    = in_glyph(in_res_q);
      src_d      = SRC_IN;
      ack_in_d   = 1'b1;
      timer_load = 1'b1;
      timer_val  = HOLD_VAL;
    end else if ((state_q == ST_SHOW) && timer_done) begin
      timer_load = 1'b1;
      timer_val  = GAP_VAL;
    end
    disp_en_d = (state_d == ST_SHOW);
  end

  always_ff @(posedge clk_div) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      src_q     <= SRC_IN;
      glyph_q   <= GLYPH_WRONG;
      disp_en_q <= 1'b0;
      ack_in_q  <= 1'b0;
      ack_ans_q <= 1'b0;
      overrun_q <= 1'b0;
      in_vld_q  <= 1'b0;
      in_res_q  <= 1'b0;
      ans_vld_q <= 1'b0;
      ans_res_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      glyph_q   <= glyph_d;
      disp_en_q <= disp_en_d;
      ack_in_q  <= ack_in_d;
      ack_ans_q <= ack_ans_d;
      overrun_q <= overrun_d;
      in_vld_q  <= in_vld_d;
      in_res_q  <= in_res_d;
      ans_vld_q <= ans_vld_d;
      ans_res_q <= ans_res_d;
    end
  end

  assign glyph   = glyph_q;
  assign disp_en = disp_en_q;
  assign ack_in  = ack_in_q;
  assign ack_ans = ack_ans_q;
  assign busy    = (state_q != ST_IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_dot_matrix_scheduler.sv
// tb/tb_dot_matrix_scheduler.sv - scoreboard bench for dot_matrix_scheduler
module tb_dot_matrix_scheduler;

  logic       clk_div = 1'b0;
  logic       rst, clear, in_req, in_ok, ans_req, ans_ok;
  logic [1:0] glyph;
  logic       disp_en, ack_in, ack_ans, busy, overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] sb[$];
  logic [2:0] sb_exp;

  dot_matrix_scheduler #(.HOLD_TICKS(4), .GAP_TICKS(2)) dut (
    .clk_div (clk_div),
    .rst     (rst),
    .clear   (clear),
    .in_req  (in_req),
    .in_ok   (in_ok),
    .ans_req (ans_req),
    .ans_ok  (ans_ok),
    .glyph   (glyph),
    .disp_en (disp_en),
    .ack_in  (ack_in),
    .ack_ans (ack_ans),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk_div = ~clk_div;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_div);
    @(negedge clk_div);
  endtask

  // Expected entry is {src (1=answer), glyph}.
  task automatic push_exp(input logic src, input logic [1:0] g);
    sb.push_back({src, g});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(sb.size() == 0 && !busy), 32'd1);
    tick();
    tick();
  endtask

  always @(negedge clk_div) begin
    if (ack_in || ack_ans) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_ack", 32'({ack_ans, glyph}), 32'd99);
      end else begin
        sb_exp = sb.pop_front();
        check_eq("ack_glyph", 32'({ack_ans, glyph}), 32'(sb_exp));
        check_eq("ack_onehot", 32'(ack_in ^ ack_ans), 32'd1);
        check_eq("ack_lit", 32'(disp_en), 32'd1);
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_req = 1'b0; in_ok = 1'b0; ans_req = 1'b0; ans_ok = 1'b0;
    tick(); tick(); tick();
    check_eq("rst_glyph", 32'(glyph), 32'd0);
    check_eq("rst_disp", 32'(disp_en), 32'd0);
    check_eq("rst_ack", 32'({ack_in, ack_ans}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // Single ok input: latency, hold and gap lengths
    in_req = 1'b1; in_ok = 1'b1; push_exp(1'b0, 2'd3);
    tick(); in_req = 1'b0;
    check_eq("t1_e0_disp", 32'(disp_en), 32'd0);
    tick();
    check_eq("t1_e1_disp", 32'(disp_en), 32'd1);
    check_eq("t1_e1_glyph", 32'(glyph), 32'd3);
    check_eq("t1_e1_ack", 32'(ack_in), 32'd1);
    for (int e = 2; e <= 4; e++) begin
      tick();
      check_eq("t1_hold_disp", 32'(disp_en), 32'd1);
      check_eq("t1_hold_ack", 32'(ack_in), 32'd0);
    end
    tick();
    check_eq("t1_e5_disp", 32'(disp_en), 32'd0);
    check_eq("t1_e5_busy", 32'(busy), 32'd1);
    tick();
    check_eq("t1_e6_busy", 32'(busy), 32'd1);
    tick();
    check_eq("t1_e7_busy", 32'(busy), 32'd0);
    check_eq("t1_e7_glyph", 32'(glyph), 32'd3);
    drain("t1_drain");

    // Same-edge requests: answer first, input after gap plus idle
    in_req = 1'b1; in_ok = 1'b0; ans_req = 1'b1; ans_ok = 1'b1;
    push_exp(1'b1, 2'd1); push_exp(1'b0, 2'd2);
    tick(); in_req = 1'b0; ans_req = 1'b0;
    tick();
    check_eq("t2_e1_glyph", 32'(glyph), 32'd1);
    for (int e = 2; e <= 7; e++) tick();
    check_eq("t2_e7_busy", 32'(busy), 32'd0);
    check_eq("t2_e7_disp", 32'(disp_en), 32'd0);
    tick();
    check_eq("t2_e8_glyph", 32'(glyph), 32'd2);
    check_eq("t2_e8_disp", 32'(disp_en), 32'd1);
    drain("t2_drain");

    // Consume and reload on the same edge is not an overrun
    in_req = 1'b1; in_ok = 1'b1; push_exp(1'b0, 2'd3);
    tick(); in_ok = 1'b0; push_exp(1'b0, 2'd2);
    tick(); in_req = 1'b0;
    check_eq("t3_overrun", 32'(overrun), 32'd0);
    drain("t3_drain");
    check_eq("t3_overrun_end", 32'(overrun), 32'd0);

    // Answer preempts a lit input glyph
    in_req = 1'b1; in_ok = 1'b1; push_exp(1'b0, 2'd3);
    tick(); in_req = 1'b0;
    tick(); tick();
    ans_req = 1'b1; ans_ok = 1'b0; push_exp(1'b1, 2'd0);
    tick(); ans_req = 1'b0;
    check_eq("t4_e3_glyph", 32'(glyph), 32'd3);
    tick();
    check_eq("t4_e4_glyph", 32'(glyph), 32'd0);
    check_eq("t4_e4_ack", 32'(ack_ans), 32'd1);
    for (int e = 5; e <= 7; e++) begin
      tick();
      check_eq("t4_hold_disp", 32'(disp_en), 32'd1);
    end
    tick();
    check_eq("t4_e8_disp", 32'(disp_en), 32'd0);
    drain("t4_drain");

    // Overwritten input during answer SHOW sets sticky overrun
    ans_req = 1'b1; ans_ok = 1'b1; push_exp(1'b1, 2'd1);
    tick(); ans_req = 1'b0;
    tick();
    in_req = 1'b1; in_ok = 1'b1;
    tick();
    check_eq("t5_e2_overrun", 32'(overrun), 32'd0);
    in_ok = 1'b0; push_exp(1'b0, 2'd2);
    tick(); in_req = 1'b0;
    check_eq("t5_e3_overrun", 32'(overrun), 32'd1);
    drain("t5_drain");
    check_eq("t5_sticky", 32'(overrun), 32'd1);

    // clear mid-SHOW with a pending slot, clear beating a same-edge request
    in_req = 1'b1; in_ok = 1'b1; push_exp(1'b0, 2'd3);
    tick(); in_req = 1'b0;
    tick();
    in_req = 1'b1; in_ok = 1'b0;
    tick(); in_req = 1'b0;
    clear = 1'b1; ans_req = 1'b1; ans_ok = 1'b1;
    tick(); clear = 1'b0; ans_req = 1'b0;
    check_eq("t6_clr_disp", 32'(disp_en), 32'd0);
    check_eq("t6_clr_busy", 32'(busy), 32'd0);
    check_eq("t6_clr_overrun", 32'(overrun), 32'd0);
    check_eq("t6_clr_glyph", 32'(glyph), 32'd3);
    tick(); tick();
    check_eq("t6_clr_stay", 32'(busy), 32'd0);

    // rst mid-SHOW with pending slot, rst beating a same-edge request
    in_req = 1'b1; in_ok = 1'b0; push_exp(1'b0, 2'd2);
    tick(); in_req = 1'b0;
    tick();
    in_req = 1'b1; in_ok = 1'b1;
    tick(); in_req = 1'b0;
    rst = 1'b1; ans_req = 1'b1; ans_ok = 1'b0;
    tick(); rst = 1'b0; ans_req = 1'b0;
    check_eq("t7_rst_disp", 32'(disp_en), 32'd0);
    check_eq("t7_rst_busy", 32'(busy), 32'd0);
    check_eq("t7_rst_glyph", 32'(glyph), 32'd0);
    for (int e = 0; e < 12; e++) tick();
    check_eq("t7_quiet_busy", 32'(busy), 32'd0);
    check_eq("t7_queue_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
